// File: rtl/ocram_pkg.sv
// ocram_pkg
//   Shared definitions for the pipelined Avalon-MM on-chip RAM:
//   controller state encoding, default lane count, per-byte even-parity
//   helper and the read-latency legality check used at elaboration.
package ocram_pkg;

    // Controller states: zero-fill sweep after reset, then normal service.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ocram_state_t;

    localparam int unsigned OCRAM_DATA_W = 16;
    localparam int unsigned BYTES        = OCRAM_DATA_W / 8;

    // Number of byte lanes for a given data width.
    function automatic int unsigned lanes_of(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Even parity: the stored bit makes the 9-bit lane XOR to zero.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic bit read_latency_ok(input int unsigned lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/ocram_mem_core.sv
// ocram_mem_core
//   Inferred single-port RAM with per-lane write enables and one
//   registered read stage. Read-before-write on a shared address.
// Ports
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset (clears the read register only)
//   clken    in   clock enable for writes and the read register
//   we       in   write enable (lanes selected by be)
//   re       in   read enable; rdata updates only on an enabled read
//   be       in   LANES lane enables
//   addr     in   ADDR_W word address
//   wdata    in   LANES*LANE_W storage word
//   rdata    out  LANES*LANE_W registered read word, holds between reads
module ocram_mem_core
    import ocram_pkg::*;
#(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned LANES  = 2,
    parameter int unsigned LANE_W = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clken,
    input  logic                       we,
    input  logic                       re,
    input  logic [LANES-1:0]           be,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [LANES*LANE_W-1:0]    wdata,
    output logic [LANES*LANE_W-1:0]    rdata
);

    localparam int unsigned WORD_W = LANES * LANE_W;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (clken && we) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    r_mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (clken && re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/ocram_avalon_pipelined.sv
// ocram_avalon_pipelined
//   Parametrised on-chip RAM Avalon-MM slave with pipelined reads
//   (readdatavalid), a post-reset zero-fill sweep that holds waitrequest,
//   and optional per-byte even parity (macro OCRAM_PARITY_EN).
// Ports
//   clk            in   system clock
//   reset_n        in   synchronous active-low reset
//   address        in   ADDR_W word address
//   byteenable     in   DATA_W/8 write lane enables
//   chipselect     in   slave select
//   read / write   in   requests; write wins when both are set
//   writedata      in   DATA_W write data
//   clken          in   global clock enable, 0 freezes all state
//   readdata       out  DATA_W read data, held while readdatavalid=0
//   readdatavalid  out  read data valid
//   waitrequest    out  high during reset and the clear sweep
//   parity_err     out  lane parity mismatch, aligned with readdatavalid
//                       (only when OCRAM_PARITY_EN is defined)
module ocram_avalon_pipelined
    import ocram_pkg::*;
#(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned ADDR_W         = 13,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                clken,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest
`ifdef OCRAM_PARITY_EN
   ,output logic                parity_err
`endif
);

    localparam int unsigned LANES  = lanes_of(DATA_W);
`ifdef OCRAM_PARITY_EN
    localparam int unsigned LANE_W = 9;
`else
    localparam int unsigned LANE_W = 8;
`endif
    localparam int unsigned WORD_W = LANES * LANE_W;
    localparam ocram_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("ocram_avalon_pipelined: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_W == 0) || (DATA_W % 8 != 0)) begin : g_bad_width
        $error("ocram_avalon_pipelined: DATA_W must be a non-zero multiple of 8");
    end

    ocram_state_t        r_state, w_state_next;
    logic [ADDR_W-1:0]   r_ptr, w_ptr_next;
    logic                w_clearing;
    logic                w_accept, w_rd_acc, w_wr_acc;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [LANES-1:0]    w_mem_be;
    logic [WORD_W-1:0]   w_wr_word, w_mem_wdata, w_core_rdata, w_out_word;
    logic                r_vld1, w_out_valid;

    // ---------------- controller FSM and clear pointer ----------------
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_clearing   = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clearing = reset_n;
                if (clken) begin
                    w_ptr_next = r_ptr + ADDR_W'(1);
                    if (r_ptr == '1) begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RESET_STATE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Held directly by reset_n so the interconnect sees a stall even
    // before the first reset edge has updated the state register.
    assign waitrequest = !reset_n || (r_state == ST_CLEAR);

    // ---------------- request acceptance ----------------
    assign w_accept = chipselect && clken && !waitrequest;
    assign w_wr_acc = w_accept && write;
    assign w_rd_acc = w_accept && read && !write;

    always_comb begin
        w_wr_word = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_wr_word[i*LANE_W +: 8] = writedata[i*8 +: 8];
`ifdef OCRAM_PARITY_EN
            w_wr_word[i*LANE_W + 8] = byte_parity(writedata[i*8 +: 8]);
`endif
        end
    end

    // The sweep borrows the single RAM port; bus requests are stalled then.
    assign w_mem_we    = w_clearing || w_wr_acc;
    assign w_mem_addr  = w_clearing ? r_ptr : address;
    assign w_mem_be    = w_clearing ? '1 : byteenable;
    assign w_mem_wdata = w_clearing ? '0 : w_wr_word;

    ocram_mem_core #(
        .ADDR_W (ADDR_W),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .clken   (clken),
        .we      (w_mem_we),
        .re      (w_rd_acc),
        .be      (w_mem_be),
        .addr    (w_mem_addr),
        .wdata   (w_mem_wdata),
        .rdata   (w_core_rdata)
    );

    // ---------------- read pipeline ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vld1 <= 1'b0;
        end else if (clken) begin
            r_vld1 <= w_rd_acc;
        end
    end

    if (READ_LATENCY == 2) begin : g_rl2
        logic [WORD_W-1:0] r_rd2;
        logic              r_vld2;

        // Capture only real results so readdata holds between reads.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_rd2  <= '0;
                r_vld2 <= 1'b0;
            end else if (clken) begin
                r_vld2 <= r_vld1;
                if (r_vld1) begin
                    r_rd2 <= w_core_rdata;
                end
            end
        end

        assign w_out_word  = r_rd2;
        assign w_out_valid = r_vld2;
    end else begin : g_rl1
        assign w_out_word  = w_core_rdata;
        assign w_out_valid = r_vld1;
    end

    assign readdatavalid = w_out_valid;

`ifdef OCRAM_PARITY_EN
    logic [LANES-1:0] w_lane_err;
`endif

    always_comb begin
        readdata = '0;
`ifdef OCRAM_PARITY_EN
        w_lane_err = '0;
`endif
        for (int unsigned i = 0; i < LANES; i++) begin
            readdata[i*8 +: 8] = w_out_word[i*LANE_W +: 8];
`ifdef OCRAM_PARITY_EN
            w_lane_err[i] = byte_parity(w_out_word[i*LANE_W +: 8]) != w_out_word[i*LANE_W + 8];
`endif
        end
    end

`ifdef OCRAM_PARITY_EN
    assign parity_err = w_out_valid && (|w_lane_err);
`endif

endmodule

// File: tb/tb_ocram_avalon_pipelined.sv
// tb_ocram_avalon_pipelined
//   Self-checking bench for ocram_avalon_pipelined (DATA_W=16, ADDR_W=4,
//   READ_LATENCY=2, CLEAR_ON_RESET=1). A behavioural memory/queue model
//   predicts every cycle; directed table rows and sequences add
//   hand-derived expectations. OCRAM_PARITY_EN enables the parity sequence.
module tb_ocram_avalon_pipelined;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned RL    = 2;
    localparam int unsigned DEPTH = 16;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, chipselect, read, write, clken;
    logic [AW-1:0] address;
    logic [1:0]    byteenable;
    logic [DW-1:0] writedata, readdata;
    logic          readdatavalid, waitrequest;
`ifdef OCRAM_PARITY_EN
    logic          parity_err;
`endif

    ocram_avalon_pipelined #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .READ_LATENCY   (RL),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .byteenable    (byteenable),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .clken         (clken),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest)
`ifdef OCRAM_PARITY_EN
       ,.parity_err    (parity_err)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [15:0] d;
        int unsigned age;
    } rd_t;

    logic [15:0] m_mem [DEPTH];
    int unsigned m_clear_left = DEPTH;
    rd_t         m_q[$];
    logic [15:0] m_last = '0;
    logic        m_valid = 1'b0;

    // One clock edge: sweep, writes, reads; results appear after RL enabled edges.
    task automatic model_step(input logic rn, cs, rd, wr, ce,
                              input logic [3:0] a, input logic [1:0] be, input logic [15:0] wd);
        rd_t nr;
        bit  push;
        if (!rn) begin
            m_q.delete();
            m_last       = '0;
            m_valid      = 1'b0;
            m_clear_left = DEPTH;
            return;
        end
        if (!ce) return;
        push = 0;
        nr.d = '0;
        nr.age = 0;
        if (m_clear_left > 0) begin
            m_mem[DEPTH - m_clear_left] = '0;
            m_clear_left--;
        end else if (cs && wr) begin
            if (be[0]) m_mem[a][7:0]  = wd[7:0];
            if (be[1]) m_mem[a][15:8] = wd[15:8];
        end else if (cs && rd) begin
            nr.d = m_mem[a];
            push = 1;
        end
        for (int i = 0; i < m_q.size(); i++) m_q[i].age++;
        while (m_q.size() > 0 && m_q[0].age > RL) void'(m_q.pop_front());
        if (push) begin
            nr.age = 1;
            m_q.push_back(nr);
        end
        m_valid = (m_q.size() > 0) && (m_q[0].age == RL);
        if (m_valid) m_last = m_q[0].d;
    endtask

    task automatic cycle(input logic rn, cs, rd, wr, ce,
                         input logic [3:0] a, input logic [1:0] be, input logic [15:0] wd);
        reset_n    = rn;
        chipselect = cs;
        read       = rd;
        write      = wr;
        clken      = ce;
        address    = a;
        byteenable = be;
        writedata  = wd;
        @(posedge clk);
        model_step(rn, cs, rd, wr, ce, a, be, wd);
        #1;
        chk("waitrequest", {31'b0, waitrequest}, {31'b0, (!rn || m_clear_left > 0)});
        chk("readdatavalid", {31'b0, readdatavalid}, {31'b0, m_valid});
        chk("readdata", {16'b0, readdata}, {16'b0, m_last});
    endtask

    task automatic idle();
        cycle(H, L, L, L, H, 4'd0, 2'b00, 16'h0);
    endtask

    task automatic rd_req(input logic [3:0] a);
        cycle(H, H, H, L, H, a, 2'b00, 16'h0);
    endtask

    task automatic wr_req(input logic [3:0] a, input logic [1:0] be, input logic [15:0] wd);
        cycle(H, H, L, H, H, a, be, wd);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        cs, rd, wr, ce;
        logic [3:0]  a;
        logic [1:0]  be;
        logic [15:0] wd;
        logic        ev;
        logic [15:0] ed;
    } vec_t;

    function automatic vec_t mk(input logic cs, rd, wr, ce, input logic [3:0] a,
                                input logic [1:0] be, input logic [15:0] wd,
                                input logic ev, input logic [15:0] ed);
        vec_t v;
        v.cs = cs; v.rd = rd; v.wr = wr; v.ce = ce; v.a = a;
        v.be = be; v.wd = wd; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    localparam int NT = 30;
    vec_t tbl [NT];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nv;

        // Expected values are stated after the clock edge of each row.
        tbl[0]  = mk(H, L, H, H, 4'd1, 2'b11, 16'h1111, L, 16'h0000);
        tbl[1]  = mk(H, L, H, H, 4'd2, 2'b11, 16'h2222, L, 16'h0000);
        tbl[2]  = mk(H, L, H, H, 4'd3, 2'b11, 16'h3333, L, 16'h0000);
        tbl[3]  = mk(H, L, H, H, 4'd5, 2'b11, 16'hBEEF, L, 16'h0000);
        tbl[4]  = mk(H, L, H, H, 4'd5, 2'b01, 16'h0012, L, 16'h0000);
        tbl[5]  = mk(H, H, L, H, 4'd5, 2'b00, 16'h0000, L, 16'h0000);
        tbl[6]  = mk(H, H, L, H, 4'd1, 2'b00, 16'h0000, H, 16'hBE12);
        tbl[7]  = mk(H, H, L, H, 4'd2, 2'b00, 16'h0000, H, 16'h1111);
        tbl[8]  = mk(H, H, L, H, 4'd3, 2'b00, 16'h0000, H, 16'h2222);
        tbl[9]  = mk(L, L, L, H, 4'd0, 2'b00, 16'h0000, H, 16'h3333);
        tbl[10] = mk(L, L, L, H, 4'd0, 2'b00, 16'h0000, L, 16'h3333);
        tbl[11] = mk(H, H, L, H, 4'd2, 2'b00, 16'h0000, L, 16'h3333);
        tbl[12] = mk(L, L, L, L, 4'd0, 2'b00, 16'h0000, L, 16'h3333);
        tbl[13] = mk(L, L, L, L, 4'd0, 2'b00, 16'h0000, L, 16'h3333);
        tbl[14] = mk(L, L, L, L, 4'd0, 2'b00, 16'h0000, L, 16'h3333);
        tbl[15] = mk(L, L, L, H, 4'd0, 2'b00, 16'h0000, H, 16'h2222);
        tbl[16] = mk(L, L, L, L, 4'd0, 2'b00, 16'h0000, H, 16'h2222);
        tbl[17] = mk(L, L, L, H, 4'd0, 2'b00, 16'h0000, L, 16'h2222);
        tbl[18] = mk(H, H, H, H, 4'd1, 2'b11, 16'hA5A5, L, 16'h2222);
        tbl[19] = mk(L, L, L, H, 4'd0, 2'b00, 16'h0000, L, 16'h2222);
        tbl[20] = mk(H, H, L, H, 4'd1, 2'b00, 16'h0000, L, 16'h2222);
        tbl[21] = mk(L, L, L, H, 4'd0, 2'b00, 16'h0000, H, 16'hA5A5);
        tbl[22] = mk(L, L, H, H, 4'd2, 2'b11, 16'hFFFF, L, 16'hA5A5);
        tbl[23] = mk(L, H, L, H, 4'd2, 2'b00, 16'h0000, L, 16'hA5A5);
        tbl[24] = mk(L, L, L, H, 4'd0, 2'b00, 16'h0000, L, 16'hA5A5);
        tbl[25] = mk(H, H, L, H, 4'd2, 2'b00, 16'h0000, L, 16'hA5A5);
        tbl[26] = mk(L, L, L, H, 4'd0, 2'b00, 16'h0000, H, 16'h2222);
        tbl[27] = mk(H, L, H, H, 4'd3, 2'b10, 16'hAB00, L, 16'h2222);
        tbl[28] = mk(H, H, L, H, 4'd3, 2'b00, 16'h0000, L, 16'h2222);
        tbl[29] = mk(L, L, L, H, 4'd0, 2'b00, 16'h0000, H, 16'hAB33);

        // Reset state
        for (int i = 0; i < 3; i++) cycle(L, H, H, L, H, 4'd0, 2'b11, 16'h0);
        chk("reset_wait", {31'b0, waitrequest}, 32'd1);

        // Clear sweep length after release
        n = 0;
        do begin
            idle();
            n++;
        end while (waitrequest && n < 100);
        chk("sweep_len", n, DEPTH);

        // Every word reads back zero
        nv = 0;
        for (int a = 0; a < DEPTH; a++) begin
            rd_req(4'(a));
            if (readdatavalid) begin
                nv++;
                chk("readall_data", {16'b0, readdata}, 32'h0);
            end
        end
        for (int i = 0; i < RL + 1; i++) begin
            idle();
            if (readdatavalid) begin
                nv++;
                chk("readall_data", {16'b0, readdata}, 32'h0);
            end
        end
        chk("readall_count", nv, DEPTH);

        // Byte lanes, back-to-back reads, clken stall, read+write, chipselect
        for (int i = 0; i < NT; i++) begin
            cycle(H, tbl[i].cs, tbl[i].rd, tbl[i].wr, tbl[i].ce, tbl[i].a, tbl[i].be, tbl[i].wd);
            chk($sformatf("tbl%0d_valid", i), {31'b0, readdatavalid}, {31'b0, tbl[i].ev});
            chk($sformatf("tbl%0d_data", i), {16'b0, readdata}, {16'b0, tbl[i].ed});
        end

        // Reset with a read in flight: the result is discarded
        rd_req(4'd5);
        cycle(L, L, L, L, H, 4'd0, 2'b00, 16'h0);
        chk("rst_inflight_valid", {31'b0, readdatavalid}, 32'd0);
        chk("rst_inflight_data", {16'b0, readdata}, 32'h0);

        // Reset pulse at sweep address 7 restarts a full sweep
        for (int i = 0; i < 7; i++) idle();
        chk("midsweep_wait", {31'b0, waitrequest}, 32'd1);
        cycle(L, L, L, L, H, 4'd0, 2'b00, 16'h0);
        n = 0;
        do begin
            idle();
            n++;
        end while (waitrequest && n < 100);
        chk("sweep_restart_len", n, DEPTH);

        wr_req(4'd6, 2'b11, 16'h7777);
        rd_req(4'd6);
        idle();
        chk("post_sweep_rd6", {16'b0, readdata}, 32'h7777);
        rd_req(4'd5);
        idle();
        chk("post_sweep_rd5_valid", {31'b0, readdatavalid}, 32'd1);
        chk("post_sweep_rd5_data", {16'b0, readdata}, 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(logic'($urandom_range(0, 149) != 0),
                  logic'($urandom_range(0, 9) < 7),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 9) < 8),
                  4'($urandom), 2'($urandom), 16'($urandom));
        end
        n = 0;
        while (waitrequest && n < 100) begin
            idle();
            n++;
        end
        chk("random_settle", {31'b0, waitrequest}, 32'd0);
        for (int i = 0; i < RL + 1; i++) idle();

`ifdef OCRAM_PARITY_EN
        // Corrupt one stored data bit; the read flags it, a clean read does not.
        wr_req(4'd3, 2'b11, 16'h5A3C);
        idle();
        dut.u_core.r_mem[3][0] = ~dut.u_core.r_mem[3][0];
        m_mem[3][0] = ~m_mem[3][0];
        rd_req(4'd3);
        idle();
        chk("par_bad_valid", {31'b0, readdatavalid}, 32'd1);
        chk("par_bad_flag", {31'b0, parity_err}, 32'd1);
        wr_req(4'd4, 2'b11, 16'h1357);
        rd_req(4'd4);
        idle();
        chk("par_clean_valid", {31'b0, readdatavalid}, 32'd1);
        chk("par_clean_flag", {31'b0, parity_err}, 32'd0);
        idle();
        chk("par_idle_flag", {31'b0, parity_err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
